// File: rtl/jtframe_68kramreq.sv
// jtframe_68kramreq: bridges a 68000 bus cycle to one SDRAM slot port.
// Ports: rst/clk; cs, ASn, UDSn, LDSn, RnW, addr, cpu_dout from the CPU;
//   bus_cs/bus_busy to the DTACK generator; cpu_din read data back;
//   sdram_req/ack/dok handshake with latched addr/we/dsn/din, sdram_dout.
// Optional macro JTFRAME_68KREQ_CACHE_EN adds a single-entry read cache.
module jtframe_68kramreq #(
    parameter int AW = 22
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cs,
    input  logic          ASn,
    input  logic          UDSn,
    input  logic          LDSn,
    input  logic          RnW,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   cpu_dout,
    output logic          bus_cs,
    output logic          bus_busy,
    output logic [15:0]   cpu_din,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_we,
    output logic [1:0]    sdram_dsn,
    output logic [15:0]   sdram_din,
    input  logic [15:0]   sdram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

    state_t state;
    logic   stale;
    logic   busn;
    logic   stale_now;
    logic   complete;

    assign busn     = ASn | (UDSn & LDSn);
    assign bus_cs   = cs;
    assign bus_busy = cs & ~busn & (state != DONE);

    // A bus cycle that ends during this very cycle also counts as stale.
    assign stale_now = stale | busn;

    // ack and dok together in REQ behave as ack followed by dok.
    assign complete = sdram_dok &
                      ((state == DATA) |
                       ((state == REQ) & sdram_ack));

`ifdef JTFRAME_68KREQ_CACHE_EN
    logic          cache_valid;
    logic [AW-1:0] cache_addr;
    logic [15:0]   cache_data;
    logic          hit;

    assign hit = cache_valid & RnW & (cache_addr == addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
        end else if (complete) begin
            if (!sdram_we) begin
                cache_valid <= 1'b1;
                cache_addr  <= sdram_addr;
                cache_data  <= sdram_dout;
            end else if (cache_addr == sdram_addr) begin
                cache_valid <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stale      <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
            sdram_dsn  <= 2'b11;
            sdram_addr <= '0;
            sdram_din  <= '0;
            cpu_din    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    stale <= 1'b0;
                    if (cs && !busn) begin
`ifdef JTFRAME_68KREQ_CACHE_EN
                        if (hit) begin
                            cpu_din <= cache_data;
                            state   <= DONE;
                        end else
`endif
                        begin
                            sdram_addr <= addr;
                            sdram_we   <= ~RnW;
                            sdram_dsn  <= {UDSn, LDSn};
                            sdram_din  <= cpu_dout;
                            sdram_req  <= 1'b1;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (busn) stale <= 1'b1;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (busn) stale <= 1'b1;
                end
                DONE: begin
                    if (busn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // The transaction always drains; only a live one reaches DONE.
            if (complete) begin
                stale <= 1'b0;
                if (stale_now) begin
                    state <= IDLE;
                end else begin
                    state <= DONE;
                    if (!sdram_we) cpu_din <= sdram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_68kramreq.sv
module tb_jtframe_68kramreq;
    localparam int AW = 22;

    logic          rst, clk, cs, ASn, UDSn, LDSn, RnW;
    logic [AW-1:0] addr;
    logic [15:0]   cpu_dout;
    logic          bus_cs, bus_busy;
    logic [15:0]   cpu_din;
    logic          sdram_req, sdram_ack, sdram_dok;
    logic [AW-1:0] sdram_addr;
    logic          sdram_we;
    logic [1:0]    sdram_dsn;
    logic [15:0]   sdram_din, sdram_dout;

    jtframe_68kramreq #(.AW(AW)) dut (
        .rst(rst), .clk(clk), .cs(cs), .ASn(ASn), .UDSn(UDSn),
        .LDSn(LDSn), .RnW(RnW), .addr(addr), .cpu_dout(cpu_dout),
        .bus_cs(bus_cs), .bus_busy(bus_busy), .cpu_din(cpu_din),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_dok(sdram_dok), .sdram_addr(sdram_addr),
        .sdram_we(sdram_we), .sdram_dsn(sdram_dsn),
        .sdram_din(sdram_din), .sdram_dout(sdram_dout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic          we;
        logic [1:0]    dsn;
        logic [15:0]   d;
    } req_t;

    req_t        req_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] mem[int];
    logic [15:0] shadow[int];
    logic [15:0] last_din = 16'h0;
    int          trans_cnt = 0;
    int          f_d1 = -1;
    int          f_d2 = -1;
    bit          cv = 0;
    int          ca = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [15:0] init_word(int a);
        return 16'(a * 40503) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] merge(logic [15:0] o, logic [15:0] n,
                                          logic [1:0] dsn);
        logic [15:0] r;
        r = o;
        if (!dsn[1]) r[15:8] = n[15:8];
        if (!dsn[0]) r[7:0]  = n[7:0];
        return r;
    endfunction

    function automatic logic [15:0] mem_rd(int a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] sh_rd(int a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    // Reference model: what the CPU access should cause, in program order.
    task automatic issue(input int a, input bit rnw, input bit udsn,
                         input bit ldsn, input logic [15:0] d,
                         input bit stale);
        bit          hit;
        logic [15:0] v;
        hit = 0;
`ifdef JTFRAME_68KREQ_CACHE_EN
        hit = rnw && cv && (ca == a);
`endif
        if (!hit) req_q.push_back('{AW'(a), !rnw, {udsn, ldsn}, d});
        if (rnw) begin
            v = sh_rd(a);
            if (!stale) begin
                exp_q.push_back(v);
                last_din = v;
            end
            cv = 1;
            ca = a;
        end else begin
            shadow[a] = merge(sh_rd(a), d, {udsn, ldsn});
            if (!stale) exp_q.push_back(last_din);
            if (cv && ca == a) cv = 0;
        end
    endtask

    task automatic wait_done(output int n);
        bit ok;
        n  = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus_busy) begin
                ok = 1;
                break;
            end
            n++;
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drive(input int a, input bit rnw, input bit udsn,
                         input bit ldsn, input logic [15:0] d);
        cs = 1; ASn = 0; RnW = rnw; UDSn = udsn; LDSn = ldsn;
        addr = AW'(a); cpu_dout = d;
    endtask

    task automatic release_bus();
        @(posedge clk); #1;
        ASn = 1; UDSn = 1; LDSn = 1; cs = 0;
    endtask

    task automatic access(input int a, input bit rnw, input bit udsn,
                          input bit ldsn, input logic [15:0] d,
                          output int busy_n);
        int hold;
        @(posedge clk); #1;
        issue(a, rnw, udsn, ldsn, d, 0);
        drive(a, rnw, udsn, ldsn, d);
        wait_done(busy_n);
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(negedge clk);
            chk("busy_in_done", 32'(bus_busy), 32'd0);
        end
        release_bus();
    endtask

    // Monitor: on DONE entry the CPU must see the scoreboarded word.
    logic prev_busy = 0;
    always @(negedge clk) begin
        if (prev_busy && cs && !(ASn | (UDSn & LDSn)) && !bus_busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cpu_din %h", cpu_din);
            end else begin
                chk("cpu_din", 32'(cpu_din), 32'(exp_q.pop_front()));
            end
        end
        prev_busy <= bus_busy;
    end

    // SDRAM slot model with random ack/dok latencies.
    initial begin
        req_t          e;
        logic [AW-1:0] la;
        logic          lwe;
        logic [1:0]    ldsn;
        logic [15:0]   ld;
        int            d1, d2;
        sdram_ack  = 0;
        sdram_dok  = 0;
        sdram_dout = 0;
        forever begin
            @(negedge clk);
            if (sdram_req === 1'b1) begin
                la = sdram_addr; lwe = sdram_we;
                ldsn = sdram_dsn; ld = sdram_din;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: addr %h", la);
                end else begin
                    e = req_q.pop_front();
                    chk("req_addr", 32'(la), 32'(e.a));
                    chk("req_we", 32'(lwe), 32'(e.we));
                    chk("req_dsn", 32'(ldsn), 32'(e.dsn));
                    if (e.we) chk("req_din", 32'(ld), 32'(e.d));
                end
                d1 = f_d1 >= 0 ? f_d1 : int'($urandom_range(0, 2));
                d2 = f_d2 >= 0 ? f_d2 : int'($urandom_range(0, 3));
                repeat (d1) begin
                    @(negedge clk);
                    chk("req_held", 32'(sdram_req), 32'd1);
                end
                chk("addr_stable", 32'(sdram_addr), 32'(la));
                sdram_ack = 1;
                trans_cnt++;
                if (d2 > 0) begin
                    @(negedge clk);
                    sdram_ack = 0;
                    repeat (d2 - 1) @(negedge clk);
                end
                sdram_dok = 1;
                if (lwe) mem[int'(la)] = merge(mem_rd(int'(la)), ld, ldsn);
                else sdram_dout = mem_rd(int'(la));
                @(negedge clk);
                sdram_ack = 0;
                sdram_dok = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t0;
        rst = 1; cs = 0; ASn = 1; UDSn = 1; LDSn = 1; RnW = 1;
        addr = 0; cpu_dout = 0;
        #7;
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_we", 32'(sdram_we), 32'd0);
        chk("rst_dsn", 32'(sdram_dsn), 32'd3);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_din", 32'(sdram_din), 32'd0);
        chk("rst_cpu_din", 32'(cpu_din), 32'd0);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        // Read 0x1234, ack late, dok later: IDLE + REQ(d1+1) + DATA(d2).
        mem[32'h1234] = 16'hBEEF;
        shadow[32'h1234] = 16'hBEEF;
        f_d1 = 2; f_d2 = 3; t0 = trans_cnt;
        access(32'h1234, 1, 0, 0, 16'h0, n);
        chk("rd_busy_cycles", 32'(n), 32'd7);
        chk("rd_one_req", 32'(trans_cnt - t0), 32'd1);
        chk("rd_cpu_din", 32'(cpu_din), 32'hBEEF);

        // Fastest access: ack on first REQ cycle, dok on first DATA cycle.
        f_d1 = 0; f_d2 = 1;
        access(32'h0040, 1, 0, 0, 16'h0, n);
        chk("min_busy_cycles", 32'(n), 32'd3);
        f_d2 = 0;
        access(32'h0041, 1, 0, 0, 16'h0, n);
        chk("ackdok_busy_cycles", 32'(n), 32'd2);

        // Upper-byte write leaves cpu_din alone.
        f_d1 = -1; f_d2 = -1;
        access(32'h1234, 1, 0, 0, 16'h0, n);
        access(32'h2000, 0, 0, 1, 16'h5A5A, n);
        chk("wr_cpu_din", 32'(cpu_din), 32'hBEEF);

        // Read-modify-write: data strobes bounce with ASn held low.
        t0 = trans_cnt;
        @(posedge clk); #1;
        issue(32'h0300, 1, 0, 0, 16'h0, 0);
        drive(32'h0300, 1, 0, 0, 16'h0);
        wait_done(n);
        @(posedge clk); #1;
        UDSn = 1; LDSn = 1;
        @(posedge clk); #1;
        issue(32'h0300, 0, 0, 0, 16'hC3C3, 0);
        drive(32'h0300, 0, 0, 0, 16'hC3C3);
        wait_done(n);
        release_bus();
        chk("rmw_two_reqs", 32'(trans_cnt - t0), 32'd2);

        // Stale read: bus cycle ends in DATA, a write follows before dok.
        f_d1 = 0; f_d2 = 5; t0 = trans_cnt;
        @(posedge clk); #1;
        issue(32'h0500, 1, 0, 0, 16'h0, 1);
        drive(32'h0500, 1, 0, 0, 16'h0);
        @(posedge clk);
        @(posedge clk); #1;
        ASn = 1;
        @(posedge clk); #1;
        issue(32'h0600, 0, 1, 0, 16'h1111, 0);
        drive(32'h0600, 0, 1, 0, 16'h1111);
        wait_done(n);
        release_bus();
        chk("stale_two_reqs", 32'(trans_cnt - t0), 32'd2);
        chk("stale_busy_cycles", 32'(n), 32'd11);
        chk("stale_cpu_din", 32'(cpu_din), 32'(last_din));
        f_d1 = -1; f_d2 = -1;

        // Unselected region: strobes low but nothing happens.
        t0 = trans_cnt;
        @(posedge clk); #1;
        cs = 0; ASn = 0; UDSn = 0; LDSn = 0; RnW = 1;
        repeat (10) begin
            @(negedge clk);
            chk("cs0_req", 32'(sdram_req), 32'd0);
            chk("cs0_busy", 32'(bus_busy), 32'd0);
        end
        chk("cs0_bus_cs", 32'(bus_cs), 32'd0);
        release_bus();
        chk("cs0_no_trans", 32'(trans_cnt - t0), 32'd0);

`ifdef JTFRAME_68KREQ_CACHE_EN
        t0 = trans_cnt;
        access(32'h0100, 1, 0, 0, 16'h0, n);
        access(32'h0100, 1, 0, 0, 16'h0, n);
        chk("cache_hit_one_req", 32'(trans_cnt - t0), 32'd1);
        t0 = trans_cnt;
        access(32'h0100, 0, 0, 0, 16'h7777, n);
        access(32'h0100, 1, 0, 0, 16'h0, n);
        chk("cache_inval_reqs", 32'(trans_cnt - t0), 32'd2);
`endif

        // Random traffic over a small address pool.
        for (int i = 0; i < 60; i++) begin
            int          a;
            bit          rnw;
            logic [1:0]  dsn;
            a   = 32'h0100 + int'($urandom_range(0, 5));
            rnw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       dsn = 2'b00;
                1:       dsn = 2'b01;
                default: dsn = 2'b10;
            endcase
            access(a, rnw, dsn[1], dsn[0], 16'($urandom), n);
        end

        repeat (5) @(negedge clk);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
